ex_div_seq: RTL and testbench
=============================

# ex_div_seq

Execute-stage division sequencer for the MIPS32 core. Runs DIV/DIVU as a 32-iteration restoring shift-subtract over multiple cycles. Holds the execute stage through a start/ready handshake and returns a 64-bit {remainder, quotient} for the HI/LO write path. It sits beside the single-cycle logic/shift ALU. The ALU result select forwards this block's result when the DIV ops are decoded.

## Interface
- No parameters; operand width fixed at 32 (`RegBus`), result width 64 (`DoubleRegBus`).
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend; sampled only on accepted start
- opdata2_i  in  32  divisor; sampled only on accepted start
- start_i  in  1  request; held high by execute stage until ready_o seen
- annul_i  in  1  cancel in-flight divide (pipeline flush)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o=1
- ready_o  out  1  result valid
- busy_o  out  1  state != IDLE; execute stage ORs it into its stall request

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 & annul_i=0 & opdata2_i=0 -> BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> ON; latch operands, cnt=0.
  - Otherwise stay IDLE.
- BYZERO -> END with result 64'h0 (no exception raised).
- ON:
  - annul_i=1 -> IDLE; no result produced.
  - Otherwise, one iteration per cycle, cnt increments. cnt==31 performs its iteration and -> END.
- END: ready_o=1, result_o stable. Stays in END while start_i=1. -> IDLE in the cycle after start_i=0, ready_o drops with it.
- Signed handling at start:
  - Latch |dividend| and |divisor| (two's complement negate when bit31 set and signed_div_i=1).
  - Record the sign of the dividend and sign(dividend) XOR sign(divisor).
- Iteration uses a 65-bit working register W, initialized {32'b0, |dividend|, 1'b0}.
  - Compute diff = W[63:32] - |divisor| with a 33-bit subtract.
  - Borrow -> W = W << 1.
  - Else -> W = {diff[31:0], W[31:0], 1'b1}.
- Finish, on entry to END:
  - Quotient = W[31:0]; remainder = W[64:33].
  - If signed and signs differ, negate the quotient.
  - If signed and dividend negative, negate the remainder.
- Overflow: -2^31 / -1 yields quotient 32'h80000000, remainder 0 (natural wrap, no trap).
- start_i while busy_o=1 is ignored; operand changes after acceptance have no effect.
- annul_i in IDLE suppresses acceptance. annul_i in BYZERO or END is ignored; the handshake completes normally.

## Timing
- Reset (sync): state=IDLE, cnt=0, result_o=64'h0, ready_o=0. W and latched operands are don't-care. rst mid-divide aborts on the next edge.
- Latency is measured from the start-accept edge (cycle 0).
  - Nonzero divisor: ON occupies cycles 1..32, ready_o=1 from cycle 33.
  - Zero divisor: ready_o=1 from cycle 2.
- ready_o, result_o and busy_o are registered or state-decoded only. There is no combinational path from inputs to outputs.
- busy_o=1 from the cycle after accept through the last END cycle. A new start is accepted no earlier than the cycle after END -> IDLE.

## Structure
- Shared defines header holds:
  - State encodings DivFree/DivByZero/DivOn/DivEnd.
  - DivResultReady/NotReady, DivStart/Stop.
  - `DoubleRegBus`.
  - New aluop codes DIV_OP/DIVU_OP and alusel RES_DIV, alongside the existing ALU codes.
- One natural sub-module: ex_div_step, a combinational 33-bit compare/subtract plus W update. Everything else stays in ex_div_seq.

## Test plan
- DIVU 100 / 7 -> after 33 cycles ready_o=1, result_o = {32'd2, 32'd14}. Hold start_i 3 more cycles: result stable. Drop start_i: ready_o=0 next cycle.
- DIV -7 / 2 -> quotient 32'hFFFFFFFD (-3), remainder 32'hFFFFFFFF (-1). DIV 7 / -2 -> quotient -3, remainder 1.
- DIV 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0. DIVU of the same operands -> quotient 0, remainder 32'h80000000.
- Divisor 0 (DIVU 5 / 0) -> ready_o=1 at cycle 2, result 64'h0. A start pulse during busy is ignored.
- annul_i at iteration 10 -> IDLE next cycle, ready_o never asserts. An immediate new DIVU 9 / 3 then returns {0, 3} with correct latency.
- rst asserted at iteration 20 -> next cycle ready_o=0, busy_o=0, result_o=0. Operand changes after accept do not alter the result.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared widths, divider FSM encodings, handshake levels and ALU op codes
package ex_div_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    typedef enum logic [1:0] {
        DIV_FREE     = 2'b00,
        DIV_BY_ZERO  = 2'b01,
        DIV_ON       = 2'b10,
        DIV_END      = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] AND_OP  = 8'b0010_0100;
    localparam logic [7:0] OR_OP   = 8'b0010_0101;
    localparam logic [7:0] XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_DIV   = 3'b110;

    function automatic logic [REG_BUS-1:0] neg32(input logic [REG_BUS-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// ex_div_step: one restoring shift-subtract iteration on the 65-bit working register
module ex_div_step
    import ex_div_pkg::*;
(
    input  logic [64:0] w_i,
    input  logic [31:0] divisor_i,
    output logic [64:0] w_o
);

    logic [32:0] diff;

    // A borrow means the divisor did not fit: shift in a 0 quotient bit, else keep the difference and shift in a 1
    always_comb begin
        diff = {1'b0, w_i[63:32]} - {1'b0, divisor_i};
        w_o  = diff[32] ? {w_i[63:0], 1'b0} : {diff[31:0], w_i[31:0], 1'b1};
    end

endmodule

// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle DIV/DIVU sequencer returning {remainder, quotient} via start/ready handshake
module ex_div_seq
    import ex_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] w_q, w_d, w_step;
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic [63:0] result_q, result_d;
    logic [31:0] dvd_abs, dvs_abs, quo, rem;

    ex_div_step u_step (
        .w_i       (w_q),
        .divisor_i (dvsr_q),
        .w_o       (w_step)
    );

    // Operand magnitudes at start, and sign-corrected results from the final iteration
    always_comb begin
        dvd_abs = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
        dvs_abs = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
        quo     = qneg_q ? neg32(w_step[31:0]) : w_step[31:0];
        rem     = rneg_q ? neg32(w_step[64:33]) : w_step[64:33];
    end

    // Next-state and datapath updates for the divide handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = 5'd0;
                        w_d     = {32'd0, dvd_abs, 1'b0};
                        dvsr_d  = dvs_abs;
                        qneg_d  = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        rneg_d  = signed_div_i && opdata1_i[31];
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = 64'd0;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    w_d   = w_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DIV_END;
                        result_d = {rem, quo};
                    end
                end
            end
            DIV_END: state_d = (start_i == DIV_STOP) ? DIV_FREE : DIV_END;
            default: state_d = DIV_FREE;
        endcase
    end

    // State and datapath registers, synchronously cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= 5'd0;
            w_q      <= 65'd0;
            dvsr_q   <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign busy_o   = (state_q != DIV_FREE);

endmodule

// File: tb/tb_ex_div_seq.sv
// tb_ex_div_seq: table-driven divide vectors plus annul, reset and busy-start sequences
module tb_ex_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    ex_div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full handshake starting from IDLE; operands are scrambled right after acceptance
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input bit hold);
        int lat;
        signed_div = s;
        op1 = a;
        op2 = b;
        start = 1'b1;
        tick();
        op1 = $urandom;
        op2 = $urandom;
        lat = 1;
        chk("busy_after_accept", 64'(busy), 64'd1);
        while (!ready && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", result, exp);
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("hold_ready", 64'(ready), 64'd1);
                chk("hold_result", result, exp);
            end
        end
        start = 1'b0;
        tick();
        chk("drop_ready", 64'(ready), 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},                   33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},      33};
        vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},             33};
        vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'd0, 32'h80000000},             33};
        vecs[4] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,   {32'h80000000, 32'd0},             33};
        vecs[5] = '{1'b0, 32'd5,         32'd0,          64'd0,                             2};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},            33};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,  32'd1,          {32'd0, 32'hFFFFFFFF},             33};
        vecs[8] = '{1'b1, 32'hFFFFFFF0,  32'd0,          64'd0,                             2};
        vecs[9] = '{1'b0, 32'd3,         32'd10,         {32'd3, 32'd0},                    33};

        rst = 1'b1;
        signed_div = 1'b0;
        op1 = 32'd0;
        op2 = 32'd0;
        start = 1'b0;
        annul = 1'b0;
        repeat (2) tick();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i == 0);

        // annul while idle blocks acceptance
        op1 = 32'd50;
        op2 = 32'd5;
        start = 1'b1;
        annul = 1'b1;
        tick();
        chk("annul_idle_busy", 64'(busy), 64'd0);
        start = 1'b0;
        annul = 1'b0;
        tick();

        // start toggling and operand changes during ON are ignored
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        tick();
        begin
            int lat;
            lat = 1;
            repeat (4) begin
                tick();
                lat++;
            end
            start = 1'b0;
            op1 = 32'd1000;
            op2 = 32'd0;
            tick();
            lat++;
            start = 1'b1;
            while (!ready && lat < 100) begin
                tick();
                lat++;
            end
            chk("busy_start_latency", 64'(lat), 64'd33);
            chk("busy_start_result", result, {32'd2, 32'd14});
            start = 1'b0;
            tick();
            chk("busy_start_idle", 64'(busy), 64'd0);
        end

        // annul at iteration 10, then an immediate fresh divide
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

        // synchronous reset at iteration 20 aborts the divide
        signed_div = 1'b1;
        op1 = 32'hFFFFFFF9;
        op2 = 32'd2;
        start = 1'b1;
        tick();
        op1 = 32'd12345;
        op2 = 32'd77;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
